// File: rtl/asynchronous_counter_pkg.sv
// Shared constants and helpers for the ripple-style binary up-counter.
// The optional terminal-count output is enabled by ASYNC_CNT_TC_EN.
package asynchronous_counter_pkg;

    localparam int ASYNC_CNT_DEFAULT_WIDTH = 4;
    localparam int ASYNC_CNT_MAX_WIDTH     = 32;

    // All-ones value for a counter of the given width, zero-extended to 32 bits.
    function automatic logic [31:0] terminal_value(input int width);
        logic [31:0] result;
        if (width >= ASYNC_CNT_MAX_WIDTH) begin
            result = 32'hFFFF_FFFF;
        end else begin
            result = (32'd1 << width) - 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/asynchronous_counter_toggle_stage.sv
// Single T flip-flop stage of the counter: toggles on clk when t_en is high,
// cleared synchronously by rst.
module toggle_stage (
    input  logic clk,
    input  logic rst,
    input  logic t_en,
    output logic q
);

    logic q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= 1'b0;
        end else if (t_en) begin
            q_reg <= ~q_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/asynchronous_counter.sv
// Free-running binary up-counter built from a chain of toggle stages whose
// carry is a combinational enable chain. Define ASYNC_CNT_TC_EN to add tc.
module asynchronous_counter
    import asynchronous_counter_pkg::*;
#(
    parameter int WIDTH = ASYNC_CNT_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q
`ifdef ASYNC_CNT_TC_EN
    ,
    output logic             tc
`endif
);

    logic [WIDTH-1:0] t_en;
    logic [WIDTH-1:0] count;

    // Stage i toggles when every lower stage is 1, i.e. stage i-1 is about to fall.
    assign t_en[0] = 1'b1;

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_carry
            assign t_en[gi] = t_en[gi-1] & count[gi-1];
        end

        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
            toggle_stage u_stage (
                .clk  (clk),
                .rst  (rst),
                .t_en (t_en[gi]),
                .q    (count[gi])
            );
        end
    endgenerate

    assign q = count;

`ifdef ASYNC_CNT_TC_EN
    localparam logic [WIDTH-1:0] TERMINAL     = WIDTH'(terminal_value(WIDTH));
    localparam logic [WIDTH-1:0] PRE_TERMINAL = TERMINAL - WIDTH'(1);

    logic tc_reg;

    // Registered flag: set on the edge that moves the count onto all-ones,
    // so it is high exactly while q holds the terminal value.
    always_ff @(posedge clk) begin
        if (rst) begin
            tc_reg <= 1'b0;
        end else begin
            tc_reg <= (count == PRE_TERMINAL);
        end
    end

    assign tc = tc_reg;
`endif

endmodule

// File: tb/tb_asynchronous_counter.sv
// Scoreboard bench for asynchronous_counter (WIDTH=4): stimulus pushes the
// expected count per edge, a monitor pops and compares just after each edge.
module tb_asynchronous_counter;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] q;
        logic         tc;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] q;
`ifdef ASYNC_CNT_TC_EN
    logic         tc;
`endif

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   edge_no   = 0;

    asynchronous_counter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .q   (q)
`ifdef ASYNC_CNT_TC_EN
        ,
        .tc  (tc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive rst for the next edge and record what q must read after it.
    task automatic step(input logic rst_val, input logic [W-1:0] exp_q, input logic exp_tc);
        exp_t e;
        @(negedge clk);
        rst    = rst_val;
        e.q    = exp_q;
        e.tc   = exp_tc;
        sb.push_back(e);
    endtask

    // Monitor: every posedge the DUT presents a new count; compare 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                edge_no++;
                total_cnt++;
                if (q === e.q) begin
                    pass_cnt++;
                    $display("edge %0d: q=%0d ok", edge_no, q);
                end else begin
                    $display("FAIL q_check edge %0d: got q=%0d expected %0d", edge_no, q, e.q);
                end
`ifdef ASYNC_CNT_TC_EN
                total_cnt++;
                if (tc === e.tc) begin
                    pass_cnt++;
                end else begin
                    $display("FAIL tc_check edge %0d: got tc=%b expected %b (q=%0d)", edge_no, tc, e.tc, q);
                end
`endif
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        total_cnt++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        rst = 1'b1;
        // Reset edge.
        step(1'b1, 4'd0, 1'b0);
        // Full sequence 1..15 then wrap to 0; tc high only at 15.
        step(1'b0, 4'd1, 1'b0);
        step(1'b0, 4'd2, 1'b0);
        step(1'b0, 4'd3, 1'b0);
        step(1'b0, 4'd4, 1'b0);
        step(1'b0, 4'd5, 1'b0);
        step(1'b0, 4'd6, 1'b0);
        step(1'b0, 4'd7, 1'b0);
        step(1'b0, 4'd8, 1'b0);
        step(1'b0, 4'd9, 1'b0);
        step(1'b0, 4'd10, 1'b0);
        step(1'b0, 4'd11, 1'b0);
        step(1'b0, 4'd12, 1'b0);
        step(1'b0, 4'd13, 1'b0);
        step(1'b0, 4'd14, 1'b0);
        step(1'b0, 4'd15, 1'b1);
        step(1'b0, 4'd0, 1'b0);
        // Count up to 6, reset mid-count, then resume from 1.
        step(1'b0, 4'd1, 1'b0);
        step(1'b0, 4'd2, 1'b0);
        step(1'b0, 4'd3, 1'b0);
        step(1'b0, 4'd4, 1'b0);
        step(1'b0, 4'd5, 1'b0);
        step(1'b0, 4'd6, 1'b0);
        step(1'b1, 4'd0, 1'b0);
        step(1'b0, 4'd1, 1'b0);
        step(1'b0, 4'd2, 1'b0);
        // Reset held for three edges.
        step(1'b1, 4'd0, 1'b0);
        step(1'b1, 4'd0, 1'b0);
        step(1'b1, 4'd0, 1'b0);
        // Ripple boundary 7 -> 8 and up to 15.
        for (int i = 1; i <= 7; i++) step(1'b0, W'(i), 1'b0);
        step(1'b0, 4'b1000, 1'b0);
        for (int i = 9; i <= 14; i++) step(1'b0, W'(i), 1'b0);
        step(1'b0, 4'b1111, 1'b1);
        // Reset while at terminal count clears both q and tc.
        step(1'b1, 4'd0, 1'b0);
        step(1'b0, 4'd1, 1'b0);
        // Let the monitor drain the scoreboard, bounded to a few edges.
        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if (sb.size() == 0) begin
            pass_cnt++;
        end else begin
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
